// File: rtl/alu_pkg.sv
// Opcode constants and FSM state type shared by the ALU arbiter and its core.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOT = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Registered logic ALU: computes on the edge where en is high, holds its result otherwise.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             err
);

    logic [WIDTH-1:0] res_d, res_q;
    logic             err_d, err_q;

    always_comb begin
        res_d = res_q;
        err_d = err_q;
        if (en) begin
            err_d = 1'b0;
            case (sel)
                OP_AND:  res_d = a & b;
                OP_OR:   res_d = a | b;
                OP_NOT:  res_d = ~a;
                OP_XOR:  res_d = a ^ b;
                default: begin
                    res_d = '0;
                    err_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            err_q <= 1'b0;
        end else begin
            res_q <= res_d;
            err_q <= err_d;
        end
    end

    assign res = res_q;
    assign err = err_q;

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a registered ALU: grant, execute, hold result until taken.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_sel,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_sel,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             res_err,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on an edge where valid and ready are both high;
    // requesters hold payload while valid && !ready, the result is held while res_valid && !res_ready.
    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [3:0]       sel_q, sel_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             id_q, id_d;
    logic             grant_id;
    logic [WIDTH-1:0] core_res;
    logic             core_err;

    assign grant_id = (req0_valid && req1_valid) ? ptr_q : req1_valid;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if ((req0_valid || req1_valid) && !rst) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    ptr_d      = ~grant_id;
                    sel_d      = grant_id ? req1_sel : req0_sel;
                    a_d        = grant_id ? req1_a : req0_a;
                    b_d        = grant_id ? req1_b : req0_b;
                    id_d       = grant_id;
                    state_d    = EXEC;
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
        end
    end

    alu_core #(.WIDTH(WIDTH)) u_core (
        .clk (clk),
        .rst (rst),
        .en  (state_q == EXEC),
        .sel (sel_q),
        .a   (a_q),
        .b   (b_q),
        .res (core_res),
        .err (core_err)
    );

    assign res_valid = (state_q == RESP);
    assign res_data  = res_valid ? core_res : '0;
    assign res_id    = res_valid & id_q;
    assign res_err   = res_valid & core_err;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int RW    = WIDTH + 2;   // packed result {id, err, data}

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [3:0]       req0_sel, req1_sel;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             res_valid, res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_id, res_err;
    logic [1:0]       dbg_state;

    logic [RW-1:0] exp_q[$];
    int n_compared   = 0;
    int n_mismatched = 0;
    logic last_granted = 1'b1;   // pointer 0 after reset == requester 1 treated as last served

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
        .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .res_err(res_err), .dbg_state(dbg_state)
    );

    // ---------------- reference model ----------------
    function automatic logic [RW-1:0] model_result(input logic id, input logic [3:0] s,
                                                   input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        case (s)
            4'b0000: return {id, 1'b0, a & b};
            4'b0001: return {id, 1'b0, a | b};
            4'b0010: return {id, 1'b0, ~a};
            4'b0011: return {id, 1'b0, a ^ b};
            default: return {id, 1'b1, {WIDTH{1'b0}}};
        endcase
    endfunction

    function automatic logic model_grant(input logic v0, input logic v1);
        if (v0 && v1) return ~last_granted;   // a tie goes to whoever was passed over last
        return v1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic [3:0] s, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
        if (n == 0) begin
            req0_valid = 1'b1; req0_sel = s; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_sel = s; req1_a = a; req1_b = b;
        end
    endtask

    task automatic apply_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        last_granted = 1'b1;
    endtask

    // Waits for a grant, drops the granted valid, waits for the result, optionally holds it
    // for `hold` cycles, then takes it. edges counts the grant edge as 1.
    task automatic transact(input int hold, output logic [1:0] grant, output logic [RW-1:0] got,
                            output int edges, output bit busy_ready, output bit unstable,
                            output bit timed_out);
        grant = 2'b00; got = '0; edges = 0; busy_ready = 0; unstable = 0; timed_out = 0;
        #1;
        for (int i = 0; i < 20 && !(req0_ready || req1_ready); i++) begin
            @(posedge clk);
            #2;
        end
        if (!(req0_ready || req1_ready)) begin
            timed_out = 1;
            return;
        end
        grant = {req1_ready, req0_ready};
        tick();
        if (grant[0]) req0_valid = 1'b0;
        else          req1_valid = 1'b0;
        edges = 1;
        while (!res_valid && edges < 20) begin
            if (req0_ready || req1_ready) busy_ready = 1;
            tick();
            edges++;
        end
        if (!res_valid) begin
            timed_out = 1;
            return;
        end
        got = {res_id, res_err, res_data};
        for (int h = 0; h < hold; h++) begin
            if (req0_ready || req1_ready) busy_ready = 1;
            tick();
            if (!res_valid || {res_id, res_err, res_data} !== got) unstable = 1;
        end
        if (req0_ready || req1_ready) busy_ready = 1;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        res_ready = 1'b0;
        set_req(0, 4'b0000, 32'h1234_5678, 32'hFFFF_FFFF);
        set_req(1, 4'b0001, 32'h0000_0001, 32'h0000_0002);
        tick();
        tick();
        #1;
        n_compared++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            n_mismatched++;
            $display("FAIL reset_ready: got %b expected 00", {req1_ready, req0_ready});
        end
        n_compared++;
        if ({res_valid, res_id, res_err, res_data} !== {3'b000, {WIDTH{1'b0}}}) begin
            n_mismatched++;
            $display("FAIL reset_outputs: got v=%b id=%b err=%b data=%h expected all zero",
                     res_valid, res_id, res_err, res_data);
        end
        n_compared++;
        if (dbg_state !== 2'd0) begin
            n_mismatched++;
            $display("FAIL reset_state: got %0d expected 0 (IDLE)", dbg_state);
        end
        apply_reset();
    endtask

    task automatic test_single();
        logic [1:0] g; logic [RW-1:0] got, exp; int edges; bit busy, unst, to;
        set_req(0, 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        exp = {1'b0, 1'b0, 32'hF000_F000};
        transact(0, g, got, edges, busy, unst, to);
        last_granted = 1'b0;
        n_compared++;
        if (to || g !== 2'b01 || got !== exp) begin
            n_mismatched++;
            $display("FAIL single_result: got grant=%b res=%h timeout=%0d expected grant=01 res=%h",
                     g, got, to, exp);
        end
        n_compared++;
        if (edges != 2) begin
            n_mismatched++;
            $display("FAIL single_latency: got %0d edges expected 2", edges);
        end
        n_compared++;
        if (res_valid !== 1'b0 || dbg_state !== 2'd0) begin
            n_mismatched++;
            $display("FAIL single_return_idle: got valid=%b state=%0d expected valid=0 state=0",
                     res_valid, dbg_state);
        end
    endtask

    task automatic test_contention();
        logic [1:0] g; logic [RW-1:0] got; int edges; bit busy, unst, to;
        apply_reset();
        set_req(0, 4'b0001, 32'h0000_00F0, 32'h0000_000F);
        set_req(1, 4'b0011, 32'hFFFF_0000, 32'h0F0F_0F0F);
        exp_q.push_back(model_result(1'b0, 4'b0001, 32'h0000_00F0, 32'h0000_000F));
        exp_q.push_back({1'b1, 1'b0, 32'hF0F0_0F0F});
        transact(0, g, got, edges, busy, unst, to);
        n_compared++;
        if (to || g !== 2'b01 || got !== exp_q[0] || busy) begin
            n_mismatched++;
            $display("FAIL contention_first: got grant=%b res=%h busy_ready=%0d expected grant=01 res=%h busy_ready=0",
                     g, got, busy, exp_q[0]);
        end
        void'(exp_q.pop_front());
        transact(0, g, got, edges, busy, unst, to);
        n_compared++;
        if (to || g !== 2'b10 || got !== exp_q[0]) begin
            n_mismatched++;
            $display("FAIL contention_second: got grant=%b res=%h expected grant=10 res=%h",
                     g, got, exp_q[0]);
        end
        void'(exp_q.pop_front());
        last_granted = 1'b1;
    endtask

    task automatic test_unsupported();
        logic [1:0] g; logic [RW-1:0] got, exp; int edges; bit busy, unst, to;
        set_req(1, 4'b0111, $urandom, $urandom);
        exp = {1'b1, 1'b1, {WIDTH{1'b0}}};
        transact(0, g, got, edges, busy, unst, to);
        last_granted = 1'b1;
        n_compared++;
        if (to || g !== 2'b10 || got !== exp) begin
            n_mismatched++;
            $display("FAIL unsupported_op: got grant=%b res=%h expected grant=10 res=%h", g, got, exp);
        end
    endtask

    task automatic test_not();
        logic [1:0] g; logic [RW-1:0] got, exp; int edges; bit busy, unst, to;
        set_req(0, 4'b0010, 32'h0000_00FF, $urandom);
        exp = {1'b0, 1'b0, 32'hFFFF_FF00};
        transact(0, g, got, edges, busy, unst, to);
        last_granted = 1'b0;
        n_compared++;
        if (to || g !== 2'b01 || got !== exp) begin
            n_mismatched++;
            $display("FAIL not_op: got grant=%b res=%h expected grant=01 res=%h", g, got, exp);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] g, g_exp; logic [RW-1:0] got, exp; int edges; bit busy, unst, to;
        logic w;
        set_req(0, 4'b0001, $urandom, $urandom);
        set_req(1, 4'b0000, $urandom, $urandom);
        w = model_grant(1'b1, 1'b1);
        g_exp = w ? 2'b10 : 2'b01;
        exp = w ? model_result(1'b1, req1_sel, req1_a, req1_b)
                : model_result(1'b0, req0_sel, req0_a, req0_b);
        transact(5, g, got, edges, busy, unst, to);
        last_granted = w;
        n_compared++;
        if (to || g !== g_exp || got !== exp) begin
            n_mismatched++;
            $display("FAIL backpressure_result: got grant=%b res=%h expected grant=%b res=%h",
                     g, got, g_exp, exp);
        end
        n_compared++;
        if (unst || busy) begin
            n_mismatched++;
            $display("FAIL backpressure_hold: got unstable=%0d ready_while_busy=%0d expected 0 0",
                     unst, busy);
        end
        n_compared++;
        if (dbg_state !== 2'd0 || res_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL backpressure_release: got state=%0d valid=%b expected state=0 valid=0",
                     dbg_state, res_valid);
        end
        exp = w ? model_result(1'b0, req0_sel, req0_a, req0_b)
                : model_result(1'b1, req1_sel, req1_a, req1_b);
        transact(0, g, got, edges, busy, unst, to);
        last_granted = ~w;
        n_compared++;
        if (to || g !== ~g_exp || got !== exp) begin
            n_mismatched++;
            $display("FAIL backpressure_drain: got grant=%b res=%h expected grant=%b res=%h",
                     g, got, ~g_exp, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] g; logic [RW-1:0] got, exp; int edges; bit busy, unst, to;
        apply_reset();
        set_req(0, 4'b0001, $urandom, $urandom);
        transact(0, g, got, edges, busy, unst, to);
        last_granted = 1'b0;
        set_req(0, 4'b0011, $urandom, $urandom);
        set_req(1, 4'b0000, $urandom, $urandom);
        #1;
        n_compared++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            n_mismatched++;
            $display("FAIL mid_pre_grant: got %b expected 10", {req1_ready, req0_ready});
        end
        tick();
        rst = 1'b1;
        tick();
        n_compared++;
        if (res_valid !== 1'b0 || dbg_state !== 2'd0 || {req1_ready, req0_ready} !== 2'b00) begin
            n_mismatched++;
            $display("FAIL mid_discard: got valid=%b state=%0d ready=%b expected 0 0 00",
                     res_valid, dbg_state, {req1_ready, req0_ready});
        end
        rst = 1'b0;
        last_granted = 1'b1;
        exp = model_result(1'b0, req0_sel, req0_a, req0_b);
        transact(0, g, got, edges, busy, unst, to);
        last_granted = 1'b0;
        n_compared++;
        if (to || g !== 2'b01 || got !== exp || edges != 2) begin
            n_mismatched++;
            $display("FAIL mid_ptr_reset: got grant=%b res=%h edges=%0d expected grant=01 res=%h edges=2",
                     g, got, edges, exp);
        end
        exp = model_result(1'b1, req1_sel, req1_a, req1_b);
        transact(0, g, got, edges, busy, unst, to);
        last_granted = 1'b1;
        n_compared++;
        if (to || g !== 2'b10 || got !== exp) begin
            n_mismatched++;
            $display("FAIL mid_requeue: got grant=%b res=%h expected grant=10 res=%h", g, got, exp);
        end
    endtask

    task automatic test_random();
        logic [1:0] g; logic [RW-1:0] got, exp; int edges; bit busy, unst, to;
        logic w;
        logic [3:0] s;
        for (int it = 0; it < 40; it++) begin
            if (!req0_valid && $urandom_range(0, 1) == 1) begin
                s = ($urandom_range(0, 2) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
                set_req(0, s, $urandom, $urandom);
            end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin
                s = ($urandom_range(0, 2) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
                set_req(1, s, $urandom, $urandom);
            end
            if (!req0_valid && !req1_valid) set_req(0, 4'($urandom_range(0, 3)), $urandom, $urandom);
            w = model_grant(req0_valid, req1_valid);
            exp_q.push_back(w ? model_result(1'b1, req1_sel, req1_a, req1_b)
                              : model_result(1'b0, req0_sel, req0_a, req0_b));
            transact($urandom_range(0, 3), g, got, edges, busy, unst, to);
            last_granted = w;
            exp = exp_q.pop_front();
            n_compared++;
            if (to || g !== (w ? 2'b10 : 2'b01) || got !== exp) begin
                n_mismatched++;
                $display("FAIL random_%0d: got grant=%b res=%h expected grant=%b res=%h",
                         it, g, got, (w ? 2'b10 : 2'b01), exp);
            end
            n_compared++;
            if (edges != 2 || busy || unst) begin
                n_mismatched++;
                $display("FAIL random_timing_%0d: got edges=%0d busy=%0d unstable=%0d expected 2 0 0",
                         it, edges, busy, unst);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        res_ready = 1'b0;
        req0_valid = 1'b0; req0_sel = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_sel = '0; req1_a = '0; req1_b = '0;
        test_reset();
        test_single();
        test_contention();
        test_unsupported();
        test_not();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width.
REQ-002 Port: clk  input  1  rising-edge clock, sole clock.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 Port: reqN_ready  output  1  operation from requester N accepted this cycle.
REQ-006 Port: reqN_sel  input  4  opcode from requester N.
REQ-007 Port: reqN_a  input  WIDTH  operand A from requester N.
REQ-008 Port: reqN_b  input  WIDTH  operand B from requester N.
REQ-009 Port: res_valid  output  1  result presented.
REQ-010 Port: res_ready  input  1  consumer takes result.
REQ-011 Port: res_data  output  WIDTH  result value.
REQ-012 Port: res_id  output  1  index of the requester that owns res_data.
REQ-013 Port: res_err  output  1  opcode was unsupported.

Function
REQ-014 Opcodes: 4'b0000 a&b; 4'b0001 a|b; 4'b0010 ~a; 4'b0011 a^b; any other value is unsupported.
REQ-015 An unsupported opcode SHALL produce res_data=0 and res_err=1; supported opcodes SHALL produce res_err=0.
REQ-016 FSM states: IDLE, EXEC, RESP; reset state IDLE.
REQ-017 IDLE: if no reqN_valid is high, remain in IDLE; otherwise grant one requester, assert its reqN_ready combinationally in that cycle, capture sel/a/b/id, and go to EXEC.
REQ-018 reqN_ready SHALL be high only in IDLE and only for the granted requester; at most one ready is high per cycle.
REQ-019 Arbitration: if only one requester is valid, grant it. If both are valid, grant the requester named by the 1-bit priority pointer.
REQ-020 On each grant, the priority pointer SHALL be set to the requester that was not granted; pointer reset value is 0.
REQ-021 EXEC: the captured operation is applied to the ALU core; go to RESP on the next edge.
REQ-022 RESP: res_valid=1 with res_data/res_id/res_err stable; on res_ready=1 return to IDLE; otherwise hold indefinitely.
REQ-023 Latency: handshake at edge T produces res_valid=1 from edge T+2; a new grant is possible no earlier than the cycle after the result handshake. Minimum 3 cycles per operation.
REQ-024 Requesters SHALL hold reqN_sel/a/b stable while reqN_valid=1 and reqN_ready=0; the block SHALL NOT depend on inputs after capture.
REQ-025 res_data/res_id/res_err SHALL be 0 whenever res_valid=0.
REQ-026 Any reqN_valid asserted during EXEC or RESP SHALL wait and SHALL NOT be dropped.

Reset
REQ-027 When rst=1 at an edge: state=IDLE, pointer=0, res_valid=0, res_data=0, res_id=0, res_err=0. reqN_ready SHALL be 0 while rst=1.
REQ-028 Reset during EXEC or RESP SHALL discard the in-flight operation with no result emitted; rst has priority over all other inputs.

Structure
REQ-029 Shared package alu_pkg SHALL hold the opcode constants (OP_AND, OP_OR, OP_NOT, OP_XOR) and the FSM state enum.
REQ-030 One sub-module, alu_core: a registered 32-bit ALU with 1-cycle latency and an err output. The arbiter SHALL contain the FSM, pointer and capture registers only.

Verification
REQ-031 Single request: req0 sel=0000 a=32'hF0F0_F0F0 b=32'hFF00_FF00 -> res_data=32'hF000_F000, res_id=0, res_err=0, res_valid at T+2.
REQ-032 Contention: both valid from reset -> req0 granted first. After res handshake, req1 granted (sel=0011 a=32'hFFFF_0000 b=32'h0F0F_0F0F -> 32'hF0F0_0F0F, res_id=1).
REQ-033 Unsupported op: req1 sel=0111 -> res_data=0, res_err=1, res_id=1.
REQ-034 Backpressure: res_ready held 0 for 5 cycles -> res_valid and res_data stable, both readys 0. Then res_ready=1 -> IDLE next cycle.
REQ-035 Reset mid-operation: rst=1 in EXEC -> no res_valid. Pointer=0, so with both requesters valid req0 wins next.
REQ-036 NOT op: req0 sel=0010 a=32'h0000_00FF -> res_data=32'hFFFF_FF00. Operand b is ignored.
